// File: rtl/ray_issue_scheduler_pkg.sv
// Shared types for the ray issue scheduler: FSM state encoding, the light-position
// vector and the fixed coordinate widths.
package ray_issue_scheduler_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StIssue,
        StDrain
    } sched_state_t;

    // Light position, three Q8.24 components
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec3_t;

    localparam int unsigned XW          = 10;
    localparam int unsigned YW          = 9;
    localparam int unsigned FrameCntW   = 16;

endpackage

// File: rtl/ray_issue_scheduler_raster_counter.sv
// Raster x/y counter: walks (0,0)..(SCREEN_W-1,SCREEN_H-1) one step per advance,
// wrapping back to (0,0) after the last pixel. Synchronous clear restarts the frame.
module ray_issue_scheduler_raster_counter
    import ray_issue_scheduler_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          last_o
);

    localparam logic [XW-1:0] XLast = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] YLast = YW'(SCREEN_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign eol_o  = (x_q == XLast);
    assign last_o = eol_o && (y_q == YLast);
    assign sof_o  = (x_q == '0) && (y_q == '0);
    assign x_o    = x_q;
    assign y_o    = y_q;

    // Next coordinate: clear wins, otherwise step in raster order
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                x_d = '0;
                y_d = last_o ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Coordinate registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/ray_issue_scheduler.sv
// Ray issue scheduler: issues pixel coordinates into the ray-marcher pipeline under
// credit-based flow control and freezes light/SDF configuration once per frame.
// Optional feature macro: SCHED_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module ray_issue_scheduler
    import ray_issue_scheduler_pkg::*;
#(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned MAX_INFLIGHT = 16,
    localparam int unsigned CRED_W      = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              out_stream_aclk_i,
    input  logic              periph_resetn_i,
    input  logic              enable_i,
    input  vec3_t             cfg_light_pos_i,
    input  logic              cfg_sdf_sel_i,
    output logic [XW-1:0]     issue_x_o,
    output logic [YW-1:0]     issue_y_o,
    output logic              issue_sof_o,
    output logic              issue_eol_o,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output vec3_t             frame_light_pos_o,
    output logic              frame_sdf_sel_o,
    input  logic              retire_i,
    output logic [CRED_W-1:0] inflight_o,
    output logic              busy_o,
    output logic              frame_done_o
`ifdef SCHED_FRAME_CNT_EN
    ,
    output logic [FrameCntW-1:0] frame_count_o
`endif
);

    localparam logic [CRED_W-1:0] MaxCred = CRED_W'(MAX_INFLIGHT);

    sched_state_t      state_q, state_d;
    logic [CRED_W-1:0] inflight_q, inflight_d;
    vec3_t             light_q;
    logic              sdf_q;
    logic              accept;
    logic              retire_eff;
    logic              last_px;
    logic              raster_clear;

    ray_issue_scheduler_raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_raster (
        .clk_i     (out_stream_aclk_i),
        .rst_ni    (periph_resetn_i),
        .clear_i   (raster_clear),
        .advance_i (accept),
        .x_o       (issue_x_o),
        .y_o       (issue_y_o),
        .sof_o     (issue_sof_o),
        .eol_o     (issue_eol_o),
        .last_o    (last_px)
    );

    assign accept     = issue_valid_o & issue_ready_i;
    // A retire with nothing outstanding is dropped so the counter cannot wrap
    assign retire_eff = retire_i && (inflight_q != '0);

    // FSM state register
    always_ff @(posedge out_stream_aclk_i or negedge periph_resetn_i) begin
        if (!periph_resetn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; enable is only looked at in idle and at frame end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StLatch;
            StLatch: state_d = StIssue;
            StIssue: if (accept && last_px) state_d = StDrain;
            StDrain: if (inflight_q == '0) state_d = enable_i ? StLatch : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; issue_valid depends on registers only, never on issue_ready
    always_comb begin
        issue_valid_o = 1'b0;
        busy_o        = 1'b1;
        frame_done_o  = 1'b0;
        raster_clear  = 1'b0;
        unique case (state_q)
            StIdle:  busy_o = 1'b0;
            StLatch: raster_clear = 1'b1;
            StIssue: issue_valid_o = (inflight_q < MaxCred);
            StDrain: frame_done_o = (inflight_q == '0);
            default: busy_o = 1'b0;
        endcase
    end

    // Credit next state: accept and retire in the same cycle cancel out
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !retire_eff) begin
            inflight_d = inflight_q + CRED_W'(1);
        end else if (!accept && retire_eff) begin
            inflight_d = inflight_q - CRED_W'(1);
        end
    end

    // Credit counter and per-frame configuration snapshot
    always_ff @(posedge out_stream_aclk_i or negedge periph_resetn_i) begin
        if (!periph_resetn_i) begin
            inflight_q <= '0;
            light_q    <= '0;
            sdf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (state_q == StLatch) begin
                light_q <= cfg_light_pos_i;
                sdf_q   <= cfg_sdf_sel_i;
            end
        end
    end

    assign inflight_o        = inflight_q;
    assign frame_light_pos_o = light_q;
    assign frame_sdf_sel_o   = sdf_q;

`ifdef SCHED_FRAME_CNT_EN
    logic [FrameCntW-1:0] frame_cnt_q;

    // Completed-frame counter, wraps naturally
    always_ff @(posedge out_stream_aclk_i or negedge periph_resetn_i) begin
        if (!periph_resetn_i) begin
            frame_cnt_q <= '0;
        end else if (frame_done_o) begin
            frame_cnt_q <= frame_cnt_q + FrameCntW'(1);
        end
    end

    assign frame_count_o = frame_cnt_q;
`endif

    // A retire with no pixel outstanding indicates a broken downstream handshake
    retire_underflow_a : assert property (
        @(posedge out_stream_aclk_i) disable iff (!periph_resetn_i)
        !(retire_i && (inflight_q == '0))
    );

endmodule
